// File: rtl/writeback_queue_pkg.sv
// Shared definitions for the pipelined writeback queue: writeback selects,
// load funct3 encodings and the per-entry control record.
package writeback_queue_pkg;

    localparam logic [1:0] WBSEL_ALU = 2'd0;
    localparam logic [1:0] WBSEL_MEM = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;
    localparam logic [1:0] WBSEL_IMM = 2'd3;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Width-independent entry fields. The DWIDTH/AWIDTH-wide fields (pc,
    // alu_res, imm, ldata) live in parameterised arrays beside this record.
    typedef struct packed {
        logic [1:0] wbsel;
        logic [4:0] rd;
        logic       rd_we;
        logic [2:0] funct3;
        logic       brtaken;
        logic       is_load;
    } wb_entry_t;

    function automatic logic wbsel_is_load(input logic [1:0] wbsel);
        return wbsel == WBSEL_MEM;
    endfunction

endpackage

// File: rtl/writeback_queue_load_extract.sv
// Load byte/half/word extraction from an aligned memory word, with sign or
// zero extension selected by funct3.
module load_extract
    import writeback_queue_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] word,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DWIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword loads use only offset[1]; a misaligned low bit is ignored.
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data = word;
        case (funct3)
            LD_LB:   data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {{(DWIDTH-8){1'b0}}, byte_sel};
            LD_LH:   data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            LD_LHU:  data = {{(DWIDTH-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue between MEM and the register file: holds up to
// DEPTH instructions, waits for in-order load data, retires one per cycle.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter  int DWIDTH = 32,
    parameter  int AWIDTH = 32,
    parameter  int DEPTH  = 4,
    localparam int PTRW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [1:0]        wbsel_i,
    input  logic [4:0]        rd_i,
    input  logic              rd_we_i,
    input  logic [2:0]        funct3_i,
    input  logic              brtaken_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              rf_we_o,
    output logic [4:0]        rf_waddr_o,
    output logic [DWIDTH-1:0] rf_wdata_o,
    output logic              retire_o,
    output logic [AWIDTH-1:0] next_pc_o,
    input  logic [4:0]        qry_rs1_i,
    input  logic [4:0]        qry_rs2_i,
    output logic              hit_rs1_o,
    output logic              hit_rs2_o,
    output logic [PTRW:0]     count_o,
    output logic              err_o
);

    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    logic [DEPTH-1:0]             ent_vld;
    logic [DEPTH-1:0]             ent_dvld;
    wb_entry_t [DEPTH-1:0]        ent_ctl;
    logic [DEPTH-1:0][AWIDTH-1:0] ent_pc;
    logic [DEPTH-1:0][DWIDTH-1:0] ent_alu;
    logic [DEPTH-1:0][DWIDTH-1:0] ent_imm;
    logic [DEPTH-1:0][DWIDTH-1:0] ent_ldata;

    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [PTRW:0]   count;
    logic            err;

    logic              tgt_found;
    logic [PTRW-1:0]   tgt_idx;
    logic              capture;
    logic [DWIDTH-1:0] ext_data;
    wb_entry_t         hd;
    logic              hd_land;
    logic              retire_now;
    logic              accept;
    logic [AWIDTH-1:0] hd_pc4;
    logic [DWIDTH-1:0] wb_data;
    logic              hit1;
    logic              hit2;

    // Responses return in issue order, so the target is the oldest load
    // still waiting. Scanning downward lets the oldest match win last.
    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = head;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_vld[head + PTRW'(k)] && ent_ctl[head + PTRW'(k)].is_load &&
                !ent_dvld[head + PTRW'(k)]) begin
                tgt_found = 1'b1;
                tgt_idx   = head + PTRW'(k);
            end
        end
    end

    assign capture = mem_rvalid_i && tgt_found;

    load_extract #(.DWIDTH(DWIDTH)) u_load_extract (
        .word   (mem_rdata_i),
        .offset (ent_alu[tgt_idx][1:0]),
        .funct3 (ent_ctl[tgt_idx].funct3),
        .data   (ext_data)
    );

    assign hd         = ent_ctl[head];
    assign hd_land    = capture && (tgt_idx == head);
    assign retire_now = ent_vld[head] && (!hd.is_load || ent_dvld[head] || hd_land);
    assign ready_o    = (count != FULL_CNT) || retire_now;
    assign accept     = valid_i && ready_o;
    assign hd_pc4     = ent_pc[head] + AWIDTH'(4);

    // A response landing on the head this cycle is bypassed straight through.
    always_comb begin
        wb_data = ent_alu[head];
        case (hd.wbsel)
            WBSEL_ALU: wb_data = ent_alu[head];
            WBSEL_MEM: wb_data = ent_dvld[head] ? ent_ldata[head] : ext_data;
            WBSEL_PC4: wb_data = DWIDTH'(hd_pc4);
            WBSEL_IMM: wb_data = ent_imm[head];
        endcase
    end

    // Entries accepted this cycle are not yet valid, so they never hit.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_ctl[i].rd_we && (ent_ctl[i].rd != 5'd0)) begin
                if (ent_ctl[i].rd == qry_rs1_i) hit1 = 1'b1;
                if (ent_ctl[i].rd == qry_rs2_i) hit2 = 1'b1;
            end
        end
    end

    assign hit_rs1_o = hit1;
    assign hit_rs2_o = hit2;
    assign count_o   = count;
    assign err_o     = err;

    // Update order matters when full: retire frees the head slot and the
    // accept written afterwards reuses it, overriding any same-slot write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_vld   <= '0;
            ent_dvld  <= '0;
            ent_ctl   <= '0;
            ent_pc    <= '0;
            ent_alu   <= '0;
            ent_imm   <= '0;
            ent_ldata <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (capture) begin
                ent_dvld[tgt_idx]  <= 1'b1;
                ent_ldata[tgt_idx] <= ext_data;
            end
            if (mem_rvalid_i && !tgt_found) err <= 1'b1;
            if (retire_now) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTRW'(1);
            end
            if (accept) begin
                ent_vld[tail]          <= 1'b1;
                ent_dvld[tail]         <= 1'b0;
                ent_ctl[tail].wbsel    <= wbsel_i;
                ent_ctl[tail].rd       <= rd_i;
                ent_ctl[tail].rd_we    <= rd_we_i;
                ent_ctl[tail].funct3   <= funct3_i;
                ent_ctl[tail].brtaken  <= brtaken_i;
                ent_ctl[tail].is_load  <= wbsel_is_load(wbsel_i);
                ent_pc[tail]           <= pc_i;
                ent_alu[tail]          <= alu_res_i;
                ent_imm[tail]          <= imm_i;
                tail                   <= tail + PTRW'(1);
            end
            case ({accept, retire_now})
                2'b10:   count <= count + (PTRW+1)'(1);
                2'b01:   count <= count - (PTRW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            retire_o   <= 1'b0;
            next_pc_o  <= '0;
        end else begin
            retire_o <= retire_now;
            rf_we_o  <= retire_now && hd.rd_we && (hd.rd != 5'd0);
            if (retire_now) begin
                rf_waddr_o <= hd.rd;
                rf_wdata_o <= wb_data;
                next_pc_o  <= hd.brtaken ? AWIDTH'(ent_alu[head]) : hd_pc4;
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: expected writes are queued as each
// instruction is driven and popped as the DUT retires.
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i, ready_o;
    logic [31:0] pc_i, alu_res_i, imm_i;
    logic [1:0]  wbsel_i;
    logic [4:0]  rd_i;
    logic        rd_we_i;
    logic [2:0]  funct3_i;
    logic        brtaken_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        retire_o;
    logic [31:0] next_pc_o;
    logic [4:0]  qry_rs1_i, qry_rs2_i;
    logic        hit_rs1_o, hit_rs2_o;
    logic [2:0]  count_o;
    logic        err_o;

    always #5 clk = ~clk;

    writeback_queue #(.DWIDTH(32), .AWIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .alu_res_i(alu_res_i), .imm_i(imm_i), .wbsel_i(wbsel_i),
        .rd_i(rd_i), .rd_we_i(rd_we_i), .funct3_i(funct3_i), .brtaken_i(brtaken_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .retire_o(retire_o), .next_pc_o(next_pc_o),
        .qry_rs1_i(qry_rs1_i), .qry_rs2_i(qry_rs2_i),
        .hit_rs1_o(hit_rs1_o), .hit_rs2_o(hit_rs2_o),
        .count_o(count_o), .err_o(err_o)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Present an instruction and record the write it must eventually produce.
    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm,
                         input logic [1:0] wbsel, input logic [4:0] rd, input logic we,
                         input logic [2:0] f3, input logic br, input logic exp_we,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_npc);
        exp_t e;
        pc_i = pc; alu_res_i = alu; imm_i = imm; wbsel_i = wbsel; rd_i = rd;
        rd_we_i = we; funct3_i = f3; brtaken_i = br; valid_i = 1'b1;
        e.waddr = rd; e.we = exp_we; e.wdata = exp_wdata; e.npc = exp_npc;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm,
                        input logic [1:0] wbsel, input logic [4:0] rd, input logic we,
                        input logic [2:0] f3, input logic br, input logic exp_we,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_npc);
        drive(pc, alu, imm, wbsel, rd, we, f3, br, exp_we, exp_wdata, exp_npc);
        #1 chk("ready_on_send", ready_o, 1);
        tick;
        valid_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        tick;
        mem_rvalid_i = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (retire_o) begin
                vectors++;
                assert (sb.size() > 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_retire: got waddr %0d want no retire", rf_waddr_o);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rf_waddr", rf_waddr_o, e.waddr);
                    chk("rf_we", rf_we_o, e.we);
                    chk("rf_wdata", rf_wdata_o, e.wdata);
                    chk("next_pc", next_pc_o, e.npc);
                end
            end else begin
                chk("idle_rf_we", rf_we_o, 0);
            end
        end
    end

    initial begin
        valid_i = 0; pc_i = 0; alu_res_i = 0; imm_i = 0; wbsel_i = 0; rd_i = 0;
        rd_we_i = 0; funct3_i = 0; brtaken_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        qry_rs1_i = 0; qry_rs2_i = 0;
        tick; tick;
        chk("rst_rf_we", rf_we_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_retire", retire_o, 0);
        chk("rst_next_pc", next_pc_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ready", ready_o, 1);
        reset = 1'b0;
        tick;

        // ALU op into an empty queue
        send(32'h1000, 32'h55, 0, WBSEL_ALU, 5'd5, 1, LD_LW, 0, 1, 32'h55, 32'h1004);
        chk("alu_count_queued", count_o, 1);
        chk("alu_not_yet", retire_o, 0);
        tick;
        chk("alu_retire", retire_o, 1);
        chk("alu_count_empty", count_o, 0);

        // LB with response three cycles after accept
        send(32'h2000, 32'h2003, 0, WBSEL_MEM, 5'd7, 1, LD_LB, 0, 1, 32'hFFFFFF80, 32'h2004);
        qry_rs1_i = 5'd7; qry_rs2_i = 5'd8;
        #1 chk("lb_hit_rs1", hit_rs1_o, 1);
        chk("lb_hit_rs2", hit_rs2_o, 0);
        tick;
        chk("lb_stall1", retire_o, 0);
        tick;
        chk("lb_stall2", retire_o, 0);
        chk("lb_hit_still", hit_rs1_o, 1);
        respond(32'h80FFFFFF);
        chk("lb_retire", retire_o, 1);
        chk("lb_count", count_o, 0);
        #1 chk("lb_hit_gone", hit_rs1_o, 0);

        // LBU, response in the first eligible cycle
        send(32'h2000, 32'h2003, 0, WBSEL_MEM, 5'd8, 1, LD_LBU, 0, 1, 32'h00000080, 32'h2004);
        respond(32'h80FFFFFF);
        chk("lbu_retire", retire_o, 1);

        // Halfword and word variants, responses back to back
        send(32'h2100, 32'h2003, 0, WBSEL_MEM, 5'd9, 1, LD_LH, 0, 1, 32'hFFFF8001, 32'h2104);
        send(32'h2104, 32'h2000, 0, WBSEL_MEM, 5'd10, 1, LD_LHU, 0, 1, 32'h00007F00, 32'h2108);
        send(32'h2108, 32'h2001, 0, WBSEL_MEM, 5'd11, 1, LD_LW, 0, 1, 32'h12345678, 32'h210C);
        chk("ld3_count", count_o, 3);
        respond(32'h80017F00);
        respond(32'h80017F00);
        respond(32'h12345678);
        chk("ld3_drained", count_o, 0);

        // PC4 wrap to x0, then taken branch with IMM writeback
        send(32'hFFFFFFFC, 0, 0, WBSEL_PC4, 5'd0, 1, LD_LW, 0, 0, 32'h0, 32'h0);
        tick;
        chk("jal_x0_retire", retire_o, 1);
        send(32'h3000, 32'h4000, 32'h1234, WBSEL_IMM, 5'd3, 1, LD_LW, 1, 1, 32'h1234, 32'h4000);
        tick;

        // Fill behind a stalled load, then retire and accept together
        send(32'h5000, 32'h100, 0, WBSEL_MEM, 5'd10, 1, LD_LW, 0, 1, 32'hCAFEF00D, 32'h5004);
        send(32'h5004, 32'h11, 0, WBSEL_ALU, 5'd11, 1, LD_LW, 0, 1, 32'h11, 32'h5008);
        send(32'h5008, 32'h12, 0, WBSEL_ALU, 5'd12, 1, LD_LW, 0, 1, 32'h12, 32'h500C);
        send(32'h500C, 32'h13, 0, WBSEL_ALU, 5'd13, 1, LD_LW, 0, 1, 32'h13, 32'h5010);
        chk("full_count", count_o, 4);
        chk("full_ready", ready_o, 0);
        qry_rs1_i = 5'd13;
        drive(32'h5010, 32'h14, 0, WBSEL_ALU, 5'd14, 1, LD_LW, 0, 1, 32'h14, 32'h5014);
        #1 chk("full_hit_rs1", hit_rs1_o, 1);
        chk("full_hold_ready", ready_o, 0);
        tick;
        chk("full_hold_count", count_o, 4);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        #1 chk("full_ready_on_retire", ready_o, 1);
        tick;
        mem_rvalid_i = 1'b0; valid_i = 1'b0;
        chk("full_swap_count", count_o, 4);
        chk("full_swap_retire", retire_o, 1);
        tick; tick; tick; tick;
        chk("full_drained", count_o, 0);

        // Response with nothing waiting
        chk("err_clear", err_o, 0);
        respond(32'h1);
        chk("err_set", err_o, 1);
        chk("err_no_retire", retire_o, 0);
        tick;
        chk("err_sticky", err_o, 1);

        // Asynchronous reset mid-operation with a pending load
        send(32'h6000, 32'h200, 0, WBSEL_MEM, 5'd20, 1, LD_LW, 0, 1, 32'h0, 32'h6004);
        send(32'h6004, 32'h21, 0, WBSEL_ALU, 5'd21, 1, LD_LW, 0, 1, 32'h21, 32'h6008);
        send(32'h6008, 32'h22, 0, WBSEL_ALU, 5'd22, 1, LD_LW, 0, 1, 32'h22, 32'h600C);
        chk("pre_rst_count", count_o, 3);
        qry_rs1_i = 5'd21;
        #2 reset = 1'b1;
        #1;
        chk("arst_count", count_o, 0);
        chk("arst_ready", ready_o, 1);
        chk("arst_rf_we", rf_we_o, 0);
        chk("arst_waddr", rf_waddr_o, 0);
        chk("arst_wdata", rf_wdata_o, 0);
        chk("arst_retire", retire_o, 0);
        chk("arst_next_pc", next_pc_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_hit", hit_rs1_o, 0);
        sb.delete();
        tick;
        reset = 1'b0;
        tick;
        respond(32'h77);
        chk("post_rst_err", err_o, 1);
        chk("post_rst_count", count_o, 0);
        chk("post_rst_retire", retire_o, 0);

        tick;
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Pipelined successor to the single-cycle writeback mux, for the pipelined core.
- Sits between the MEM stage and the register file.
- Buffers up to DEPTH completed instructions in order, and waits for variable-latency load data.
- Performs load byte/half extraction with sign or zero extension, then retires one entry per cycle as a registered register-file write and a registered next-PC.

Parameters:
DWIDTH, 32, data width of ALU, immediate, memory and write data
AWIDTH, 32, address/PC width
DEPTH, 4, queue entries; power of two, >= 2
PTRW, $clog2(DEPTH), derived pointer width; not overridable

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid_i  in  1  MEM stage presents an instruction
ready_o  out  1  queue can accept this cycle
pc_i  in  AWIDTH  instruction PC
alu_res_i  in  DWIDTH  ALU result; branch target or load address
imm_i  in  DWIDTH  immediate
wbsel_i  in  2  WBSEL_ALU/MEM/PC4/IMM
rd_i  in  5  destination register
rd_we_i  in  1  instruction writes rd
funct3_i  in  3  load size/sign (LB, LH, LW, LBU, LHU)
brtaken_i  in  1  branch/jump taken
mem_rvalid_i  in  1  load response valid; responses return in load-issue order
mem_rdata_i  in  DWIDTH  raw aligned memory word
rf_we_o  out  1  register-file write enable (registered)
rf_waddr_o  out  5  write address (registered)
rf_wdata_o  out  DWIDTH  write data (registered)
retire_o  out  1  one instruction retired last cycle
next_pc_o  out  AWIDTH  next PC of the last retired instruction
qry_rs1_i, qry_rs2_i  in  5 each  hazard query registers
hit_rs1_o, hit_rs2_o  out  1 each  a queued, unretired entry writes that register (x0 never hits)
count_o  out  PTRW+1  occupied entries
err_o  out  1  sticky: a response arrived with no load awaiting data

Behaviour:
- Reset (async, any time, including mid-operation):
  - empties the queue and clears both pointers and all entry valid/data-valid bits;
  - drives rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, retire_o=0, next_pc_o=0, count_o=0, err_o=0;
  - pending load responses are discarded.
- Entry contents:
  - pc, alu_res, imm, wbsel, rd, rd_we, funct3, brtaken, is_load (wbsel==WBSEL_MEM), dvalid, ldata.
- Accept:
  - occurs when valid_i && ready_o; the entry is written at the tail.
  - ready_o = !full || retire_now, so a full queue accepts in the same cycle the head retires.
- Load data capture:
  - On mem_rvalid_i, the response goes to the oldest valid entry with is_load && !dvalid.
  - That entry stores extracted data and sets dvalid.
  - If no such entry exists, nothing is stored and err_o sets and stays set until reset.
  - An entry accepted in the same cycle is not eligible for a response.
- Extraction, offset = alu_res[1:0]:
  - LB/LBU select byte[offset], sign- or zero-extended.
  - LH/LHU select halfword[offset[1]], sign- or zero-extended; offset[0] is ignored.
  - LW passes the word and ignores the offset.
  - Other funct3 values behave as LW.
- Retire:
  - retire_now = head valid && (!is_load || dvalid || response landing on head this cycle).
  - The same-cycle response is bypassed; at most one retire per cycle.
  - Next edge after retire_now:
    - retire_o=1 and rf_waddr_o=rd;
    - rf_we_o = rd_we && rd!=0;
    - rf_wdata_o from the mux: ALU=alu_res, MEM=extracted data, PC4=pc+4, IMM=imm; the 2-bit mux is complete, so there is no default case;
    - next_pc_o = brtaken ? alu_res : pc+4, with AWIDTH-wrap arithmetic.
  - With no retire, retire_o=0 and rf_we_o=0; rf_waddr_o, rf_wdata_o and next_pc_o hold their values.
- Latency:
  - A non-load accepted into an empty queue at cycle N appears on rf_we_o at N+1.
  - A load whose response arrives at cycle M (M ≥ N+1) and which is at the head appears at M+1.
- Pointers and count:
  - Pointers wrap modulo DEPTH.
  - count_o increments on accept only, decrements on retire only, and is unchanged when both or neither happen.
- Hazard hits:
  - Combinational over valid entries with rd_we && rd!=0.
  - An entry retiring this cycle still hits.
  - An entry being accepted this cycle does not hit.

Decomposition:
- Shared package:
  - existing WBSEL_* constants;
  - new LD_LB/LD_LH/LD_LW/LD_LBU/LD_LHU funct3 constants;
  - wb_entry_t packed struct for the entry fields.
- One combinational sub-module, load_extract, parameterised by DWIDTH, with inputs (word, offset, funct3) and output the extended data.

Test Plan:
- ALU op, pc=0x1000, alu=0x55, rd=5, wbsel=ALU, into an empty queue -> next cycle rf_we_o=1, waddr=5, wdata=0x55, next_pc_o=0x1004.
- Load LB, alu=0x2003, rd=7, mem_rdata=0x80FFFFFF 3 cycles later -> stalls 3 cycles, hit_rs1_o=1 for qry_rs1=7, then wdata=0xFFFFFF80; the LBU variant gives 0x00000080.
- Jump, pc=0xFFFFFFFC, brtaken=0, wbsel=PC4 -> wdata=0x00000000, next_pc_o=0x00000000 (wrap); rd=0 -> rf_we_o=0, retire_o=1.
- Fill DEPTH entries behind a stalled head load -> ready_o=0, count_o=4. Response arrives while valid_i is held -> head retires and the new entry is accepted in the same cycle; count_o stays 4; strict in-order writes follow.
- mem_rvalid_i with the queue empty -> err_o=1 and stays set; no write occurs.
- Assert reset with 3 entries and 1 pending load -> all outputs 0, count_o=0, ready_o=1 asynchronously. A later spurious response sets err_o.
